// File: rtl/addr_decoder_cfg_dbuf_pkg.sv
// Shared constants, address-map helpers and commit FSM state type for the
// double-buffered address decoder config store.
package addr_decoder_cfg_pkg;

  localparam int CTRL_COMMIT  = 0;
  localparam int CTRL_LOCK    = 1;
  localparam int CTRL_ERR_CLR = 2;
  localparam int CTRL_RD_SEL  = 3;

  localparam logic [7:0] OP_RESET = 8'hFF;

  typedef enum logic [1:0] {
    CS_IDLE  = 2'd0,
    CS_WAIT  = 2'd1,
    CS_APPLY = 2'd2
  } cfg_state_t;

  function automatic int cfg_bytes(input int addr_w);
    return (addr_w + 7) / 8;
  endfunction

  function automatic int mask_off(input int addr_w, input int num_win);
    return num_win * cfg_bytes(addr_w);
  endfunction

  function automatic int slot_off(input int addr_w, input int num_win);
    return mask_off(addr_w, num_win) + num_win * cfg_bytes(addr_w);
  endfunction

  function automatic int op_off(input int addr_w, input int num_win);
    return slot_off(addr_w, num_win) + num_win;
  endfunction

  function automatic int en_off(input int addr_w, input int num_win);
    return op_off(addr_w, num_win) + num_win;
  endfunction

  function automatic int ctrl_off(input int addr_w, input int num_win);
    return en_off(addr_w, num_win) + (num_win + 7) / 8;
  endfunction

endpackage

// File: rtl/addr_decoder_cfg_dbuf_if.sv
// Byte-wide host configuration bus: write/read strobes, address, data and
// the registered read-data return.
interface addr_decoder_cfg_dbuf_if #(
  parameter int CFG_AW = 10
) ();
  logic              cfg_we;
  logic              cfg_re;
  logic [CFG_AW-1:0] cfg_addr;
  logic [7:0]        cfg_wdata;
  logic [7:0]        cfg_rdata;
  logic              cfg_rvalid;

  modport master (
    output cfg_we, cfg_re, cfg_addr, cfg_wdata,
    input  cfg_rdata, cfg_rvalid
  );

  modport slave (
    input  cfg_we, cfg_re, cfg_addr, cfg_wdata,
    output cfg_rdata, cfg_rvalid
  );
endinterface

// File: rtl/addr_decoder_cfg_dbuf_field.sv
// One shadow/active register pair: byte-addressed writes into the shadow copy,
// whole-field copy into the active copy when copy_en is high.
module cfg_dbuf_field #(
  parameter int             W   = 8,
  parameter logic [W-1:0]   RST = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [7:0]   byte_idx,
  input  logic [7:0]   wdata,
  input  logic         copy_en,
  output logic [W-1:0] shadow,
  output logic [W-1:0] active
);
  logic [W-1:0] shadow_r;
  logic [W-1:0] active_r;
  logic [W-1:0] shadow_nxt_s;

  // bits above W in the top byte have no storage and are simply dropped
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign shadow_nxt_s[i] = (we && (byte_idx == 8'(i / 8))) ? wdata[i % 8] : shadow_r[i];
  end

  // Shadow takes host bytes; active snapshots the pre-write shadow on copy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_r <= RST;
      active_r <= RST;
    end else begin
      shadow_r <= shadow_nxt_s;
      if (copy_en) begin
        active_r <= shadow_r;
      end
    end
  end

  assign shadow = shadow_r;
  assign active = active_r;
endmodule

// File: rtl/addr_decoder_cfg_dbuf.sv
// Double-buffered config store for the Dock address decoder: host writes shadow
// tables bytewise, a commit FSM copies shadow to active once the decoder is idle.
module addr_decoder_cfg_dbuf
  import addr_decoder_cfg_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int NUM_WIN = 16,
  parameter int SLOT_W  = 3,
  parameter int CFG_AW  = 10
) (
  input  logic                      cfg_clk,
  input  logic                      cfg_rst_n,
  addr_decoder_cfg_dbuf_if.slave    cfg_bus,
  input  logic                      commit_hold,
  output logic                      cfg_updated,
  output logic [NUM_WIN*ADDR_W-1:0] base_flat,
  output logic [NUM_WIN*ADDR_W-1:0] mask_flat,
  output logic [NUM_WIN*SLOT_W-1:0] slot_flat,
  output logic [NUM_WIN*8-1:0]      op_flat,
  output logic [NUM_WIN-1:0]        en_flat,
  output logic                      cfg_locked,
  output logic                      cfg_err
);
  localparam logic [31:0] CB     = 32'(cfg_bytes(ADDR_W));
  localparam logic [31:0] MASK_O = 32'(mask_off(ADDR_W, NUM_WIN));
  localparam logic [31:0] SLOT_O = 32'(slot_off(ADDR_W, NUM_WIN));
  localparam logic [31:0] OP_O   = 32'(op_off(ADDR_W, NUM_WIN));
  localparam logic [31:0] EN_O   = 32'(en_off(ADDR_W, NUM_WIN));
  localparam logic [31:0] CTRL_O = 32'(ctrl_off(ADDR_W, NUM_WIN));
  localparam logic [31:0] AW32   = 32'(ADDR_W);
  localparam logic [31:0] SW32   = 32'(SLOT_W);

  if (ctrl_off(ADDR_W, NUM_WIN) >= (1 << CFG_AW)) begin : g_cfg_aw_check
    $error("addr_decoder_cfg_dbuf: CTRL_OFF does not fit in CFG_AW address bits");
  end

  cfg_state_t state_r, state_nxt_s;
  logic        locked_r, err_r, rd_sel_r, updated_r, rvalid_r;
  logic [7:0]  rdata_r, rd_byte_s, byt_s;
  logic [31:0] addr_s, win_s;
  logic        sel_base_s, sel_mask_s, sel_slot_s, sel_op_s, sel_en_s, sel_ctrl_s, sel_oor_s;
  logic        tbl_we_s, ctrl_we_s, commit_req_s, err_set_s, err_nxt_s, copy_en_s, pending_s;
  logic [NUM_WIN*ADDR_W-1:0] base_sh_s, mask_sh_s;
  logic [NUM_WIN*SLOT_W-1:0] slot_sh_s;
  logic [NUM_WIN*8-1:0]      op_sh_s;
  logic [NUM_WIN-1:0]        en_sh_s;
  logic [ADDR_W-1:0]         base_word_s, mask_word_s;

  assign addr_s = 32'(cfg_bus.cfg_addr);

  // Address decode: table region, window index and byte-within-field.
  always_comb begin
    sel_base_s = (addr_s < MASK_O);
    sel_mask_s = (addr_s >= MASK_O) && (addr_s < SLOT_O);
    sel_slot_s = (addr_s >= SLOT_O) && (addr_s < OP_O);
    sel_op_s   = (addr_s >= OP_O) && (addr_s < EN_O);
    sel_en_s   = (addr_s >= EN_O) && (addr_s < CTRL_O);
    sel_ctrl_s = (addr_s == CTRL_O);
    sel_oor_s  = (addr_s > CTRL_O);
    win_s      = 32'd0;
    byt_s      = 8'd0;
    if (sel_base_s) begin
      win_s = addr_s / CB;
      byt_s = 8'(addr_s % CB);
    end else if (sel_mask_s) begin
      win_s = (addr_s - MASK_O) / CB;
      byt_s = 8'((addr_s - MASK_O) % CB);
    end else if (sel_slot_s) begin
      win_s = addr_s - SLOT_O;
    end else if (sel_op_s) begin
      win_s = addr_s - OP_O;
    end else if (sel_en_s) begin
      byt_s = 8'(addr_s - EN_O);
    end else begin
      win_s = 32'd0;
      byt_s = 8'd0;
    end
  end

  assign tbl_we_s     = cfg_bus.cfg_we && (addr_s < CTRL_O) && !locked_r;
  assign ctrl_we_s    = cfg_bus.cfg_we && sel_ctrl_s;
  assign commit_req_s = ctrl_we_s && cfg_bus.cfg_wdata[CTRL_COMMIT];
  assign err_set_s    = cfg_bus.cfg_we && (sel_oor_s || ((addr_s < CTRL_O) && locked_r));
  assign pending_s    = (state_r != CS_IDLE);

  for (genvar w = 0; w < NUM_WIN; w++) begin : g_win
    logic hit_s;
    assign hit_s = (win_s == 32'(w));

    cfg_dbuf_field #(.W(ADDR_W), .RST('0)) u_base (
      .clk(cfg_clk), .rst_n(cfg_rst_n), .we(tbl_we_s && sel_base_s && hit_s),
      .byte_idx(byt_s), .wdata(cfg_bus.cfg_wdata), .copy_en(copy_en_s),
      .shadow(base_sh_s[w*ADDR_W +: ADDR_W]), .active(base_flat[w*ADDR_W +: ADDR_W])
    );
    cfg_dbuf_field #(.W(ADDR_W), .RST('0)) u_mask (
      .clk(cfg_clk), .rst_n(cfg_rst_n), .we(tbl_we_s && sel_mask_s && hit_s),
      .byte_idx(byt_s), .wdata(cfg_bus.cfg_wdata), .copy_en(copy_en_s),
      .shadow(mask_sh_s[w*ADDR_W +: ADDR_W]), .active(mask_flat[w*ADDR_W +: ADDR_W])
    );
    cfg_dbuf_field #(.W(SLOT_W), .RST('0)) u_slot (
      .clk(cfg_clk), .rst_n(cfg_rst_n), .we(tbl_we_s && sel_slot_s && hit_s),
      .byte_idx(8'd0), .wdata(cfg_bus.cfg_wdata), .copy_en(copy_en_s),
      .shadow(slot_sh_s[w*SLOT_W +: SLOT_W]), .active(slot_flat[w*SLOT_W +: SLOT_W])
    );
    cfg_dbuf_field #(.W(8), .RST(OP_RESET)) u_op (
      .clk(cfg_clk), .rst_n(cfg_rst_n), .we(tbl_we_s && sel_op_s && hit_s),
      .byte_idx(8'd0), .wdata(cfg_bus.cfg_wdata), .copy_en(copy_en_s),
      .shadow(op_sh_s[w*8 +: 8]), .active(op_flat[w*8 +: 8])
    );
  end

  cfg_dbuf_field #(.W(NUM_WIN), .RST('0)) u_en (
    .clk(cfg_clk), .rst_n(cfg_rst_n), .we(tbl_we_s && sel_en_s),
    .byte_idx(byt_s), .wdata(cfg_bus.cfg_wdata), .copy_en(copy_en_s),
    .shadow(en_sh_s), .active(en_flat)
  );

  // Read mux over shadow or active copy; values are those before any same-cycle write.
  always_comb begin
    base_word_s = ADDR_W'((rd_sel_r ? base_flat : base_sh_s) >> (win_s * AW32));
    mask_word_s = ADDR_W'((rd_sel_r ? mask_flat : mask_sh_s) >> (win_s * AW32));
    if (sel_base_s) begin
      rd_byte_s = 8'(base_word_s >> {byt_s, 3'b000});
    end else if (sel_mask_s) begin
      rd_byte_s = 8'(mask_word_s >> {byt_s, 3'b000});
    end else if (sel_slot_s) begin
      rd_byte_s = 8'(SLOT_W'((rd_sel_r ? slot_flat : slot_sh_s) >> (win_s * SW32)));
    end else if (sel_op_s) begin
      rd_byte_s = 8'((rd_sel_r ? op_flat : op_sh_s) >> {win_s, 3'b000});
    end else if (sel_en_s) begin
      rd_byte_s = 8'((rd_sel_r ? en_flat : en_sh_s) >> {byt_s, 3'b000});
    end else if (sel_ctrl_s) begin
      rd_byte_s = {4'b0000, rd_sel_r, err_r, locked_r, pending_s};
    end else begin
      rd_byte_s = 8'h00;
    end
  end

  // Commit FSM: a request waits out commit_hold, then one APPLY cycle; requests while busy merge.
  always_comb begin
    state_nxt_s = state_r;
    copy_en_s   = 1'b0;
    case (state_r)
      CS_IDLE: begin
        if (commit_req_s) state_nxt_s = CS_WAIT;
        else              state_nxt_s = CS_IDLE;
      end
      CS_WAIT: begin
        if (!commit_hold) begin
          state_nxt_s = CS_APPLY;
          copy_en_s   = 1'b1;
        end else begin
          state_nxt_s = CS_WAIT;
        end
      end
      CS_APPLY: state_nxt_s = CS_IDLE;
      default:  state_nxt_s = CS_IDLE;
    endcase
  end

  // Sticky error: a new error wins over a same-cycle clear.
  always_comb begin
    if (err_set_s) begin
      err_nxt_s = 1'b1;
    end else if (ctrl_we_s && cfg_bus.cfg_wdata[CTRL_ERR_CLR]) begin
      err_nxt_s = 1'b0;
    end else begin
      err_nxt_s = err_r;
    end
  end

  // Status, read return and FSM state registers.
  always_ff @(posedge cfg_clk) begin
    if (!cfg_rst_n) begin
      state_r   <= CS_IDLE;
      locked_r  <= 1'b0;
      err_r     <= 1'b0;
      rd_sel_r  <= 1'b0;
      updated_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rdata_r   <= 8'h00;
    end else begin
      state_r   <= state_nxt_s;
      err_r     <= err_nxt_s;
      updated_r <= copy_en_s;
      rvalid_r  <= cfg_bus.cfg_re;
      rdata_r   <= cfg_bus.cfg_re ? rd_byte_s : 8'h00;
      if (ctrl_we_s) begin
        locked_r <= locked_r | cfg_bus.cfg_wdata[CTRL_LOCK];
        rd_sel_r <= cfg_bus.cfg_wdata[CTRL_RD_SEL];
      end
    end
  end

  assign cfg_bus.cfg_rdata  = rdata_r;
  assign cfg_bus.cfg_rvalid = rvalid_r;
  assign cfg_updated        = updated_r;
  assign cfg_locked         = locked_r;
  assign cfg_err            = err_r;
endmodule

// File: tb/tb_addr_decoder_cfg_dbuf.sv
// Bench for addr_decoder_cfg_dbuf: directed scenarios with literal expectations,
// then randomized traffic checked each cycle against a table-level model.
module tb_addr_decoder_cfg_dbuf;
  localparam int ADDR_W  = 32;
  localparam int NUM_WIN = 16;
  localparam int SLOT_W  = 3;
  localparam int CFG_AW  = 10;
  localparam int MASK_O  = 64;
  localparam int SLOT_O  = 128;
  localparam int OP_O    = 144;
  localparam int EN_O    = 160;
  localparam int CTRL_O  = 162;

  logic cfg_clk = 1'b0;
  logic cfg_rst_n = 1'b0;
  logic commit_hold = 1'b0;
  logic cfg_updated, cfg_locked, cfg_err;
  logic [NUM_WIN*ADDR_W-1:0] base_flat, mask_flat;
  logic [NUM_WIN*SLOT_W-1:0] slot_flat;
  logic [NUM_WIN*8-1:0]      op_flat;
  logic [NUM_WIN-1:0]        en_flat;

  always #5 cfg_clk = ~cfg_clk;

  addr_decoder_cfg_dbuf_if #(.CFG_AW(CFG_AW)) bus ();

  addr_decoder_cfg_dbuf #(.ADDR_W(ADDR_W), .NUM_WIN(NUM_WIN), .SLOT_W(SLOT_W), .CFG_AW(CFG_AW)) dut (
    .cfg_clk(cfg_clk), .cfg_rst_n(cfg_rst_n), .cfg_bus(bus), .commit_hold(commit_hold),
    .cfg_updated(cfg_updated), .base_flat(base_flat), .mask_flat(mask_flat),
    .slot_flat(slot_flat), .op_flat(op_flat), .en_flat(en_flat),
    .cfg_locked(cfg_locked), .cfg_err(cfg_err)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // behavioural model: plain arrays of shadow/active table entries
  bit [31:0] m_base_sh[NUM_WIN], m_base_ac[NUM_WIN], m_mask_sh[NUM_WIN], m_mask_ac[NUM_WIN];
  bit [2:0]  m_slot_sh[NUM_WIN], m_slot_ac[NUM_WIN];
  bit [7:0]  m_op_sh[NUM_WIN], m_op_ac[NUM_WIN];
  bit [15:0] m_en_sh, m_en_ac;
  bit        m_locked, m_err, m_rd_sel, m_upd, m_rvalid;
  bit [7:0]  m_rdata;
  int        m_phase;  // 0 no commit outstanding, 1 waiting for hold release, 2 apply cycle

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void m_reset();
    for (int w = 0; w < NUM_WIN; w++) begin
      m_base_sh[w] = 32'h0; m_base_ac[w] = 32'h0;
      m_mask_sh[w] = 32'h0; m_mask_ac[w] = 32'h0;
      m_slot_sh[w] = 3'h0;  m_slot_ac[w] = 3'h0;
      m_op_sh[w]   = 8'hFF; m_op_ac[w]   = 8'hFF;
    end
    m_en_sh = 16'h0; m_en_ac = 16'h0;
    m_locked = 1'b0; m_err = 1'b0; m_rd_sel = 1'b0;
    m_upd = 1'b0; m_rvalid = 1'b0; m_rdata = 8'h00; m_phase = 0;
  endfunction

  function automatic bit [7:0] m_read(input int a);
    bit [31:0] wv;
    bit [15:0] ev;
    if (a < MASK_O) begin
      wv = m_rd_sel ? m_base_ac[a/4] : m_base_sh[a/4];
      return wv[(a%4)*8 +: 8];
    end else if (a < SLOT_O) begin
      wv = m_rd_sel ? m_mask_ac[(a-MASK_O)/4] : m_mask_sh[(a-MASK_O)/4];
      return wv[((a-MASK_O)%4)*8 +: 8];
    end else if (a < OP_O) begin
      return {5'b0, (m_rd_sel ? m_slot_ac[a-SLOT_O] : m_slot_sh[a-SLOT_O])};
    end else if (a < EN_O) begin
      return m_rd_sel ? m_op_ac[a-OP_O] : m_op_sh[a-OP_O];
    end else if (a < CTRL_O) begin
      ev = m_rd_sel ? m_en_ac : m_en_sh;
      return ev[(a-EN_O)*8 +: 8];
    end else if (a == CTRL_O) begin
      return {4'b0, m_rd_sel, m_err, m_locked, (m_phase != 0)};
    end
    return 8'h00;
  endfunction

  function automatic void m_step(input bit we, input bit re, input int a, input bit [7:0] d,
                                 input bit hold, input bit rst_n);
    int ph0;
    if (!rst_n) begin
      m_reset();
      return;
    end
    ph0 = m_phase;
    m_rvalid = re;
    m_rdata = re ? m_read(a) : 8'h00;
    m_upd = 1'b0;
    if (ph0 == 2) m_phase = 0;
    else if (ph0 == 1 && !hold) begin
      m_base_ac = m_base_sh; m_mask_ac = m_mask_sh; m_slot_ac = m_slot_sh;
      m_op_ac = m_op_sh; m_en_ac = m_en_sh;
      m_upd = 1'b1; m_phase = 2;
    end
    if (we) begin
      if (a > CTRL_O) m_err = 1'b1;
      else if (a == CTRL_O) begin
        if (d[0] && ph0 == 0) m_phase = 1;
        m_locked = m_locked | d[1];
        m_rd_sel = d[3];
        if (d[2]) m_err = 1'b0;
      end else if (m_locked) m_err = 1'b1;
      else if (a < MASK_O) m_base_sh[a/4][(a%4)*8 +: 8] = d;
      else if (a < SLOT_O) m_mask_sh[(a-MASK_O)/4][((a-MASK_O)%4)*8 +: 8] = d;
      else if (a < OP_O) m_slot_sh[a-SLOT_O] = d[2:0];
      else if (a < EN_O) m_op_sh[a-OP_O] = d;
      else m_en_sh[(a-EN_O)*8 +: 8] = d;
    end
  endfunction

  task automatic cyc(input bit we, input bit re, input int a, input bit [7:0] d,
                     input bit hold, input bit rst_n);
    bus.cfg_we = we; bus.cfg_re = re; bus.cfg_addr = CFG_AW'(a); bus.cfg_wdata = d;
    commit_hold = hold; cfg_rst_n = rst_n;
    @(posedge cfg_clk);
    m_step(we, re, a, d, hold, rst_n);
    chk_en = 1'b1;
    @(negedge cfg_clk);
  endtask

  logic [NUM_WIN*ADDR_W-1:0] e_base, e_mask;
  logic [NUM_WIN*SLOT_W-1:0] e_slot;
  logic [NUM_WIN*8-1:0]      e_op;

  // per-cycle comparison of every output against the model
  always @(negedge cfg_clk) begin
    if (chk_en) begin
      for (int w = 0; w < NUM_WIN; w++) begin
        e_base[w*ADDR_W +: ADDR_W] = m_base_ac[w];
        e_mask[w*ADDR_W +: ADDR_W] = m_mask_ac[w];
        e_slot[w*SLOT_W +: SLOT_W] = m_slot_ac[w];
        e_op[w*8 +: 8]             = m_op_ac[w];
      end
      chk("rvalid", bus.cfg_rvalid, m_rvalid);
      if (m_rvalid) chk("rdata", bus.cfg_rdata, m_rdata);
      chk("updated", cfg_updated, m_upd);
      chk("locked", cfg_locked, m_locked);
      chk("err", cfg_err, m_err);
      chk("base_flat", base_flat, e_base);
      chk("mask_flat", mask_flat, e_mask);
      chk("slot_flat", slot_flat, e_slot);
      chk("op_flat", op_flat, e_op);
      chk("en_flat", en_flat, m_en_ac);
    end
  end

  initial begin
    bit hold_v;
    int r, a;
    bit we, re, rst;
    bit [7:0] d;
    cyc(0, 0, 0, 8'h00, 0, 0);
    cyc(0, 0, 0, 8'h00, 0, 0);
    // reset defaults
    cyc(0, 1, 144, 8'h00, 0, 1);
    chk("t1_rd_op", bus.cfg_rdata, 8'hFF);
    chk("t1_rvalid", bus.cfg_rvalid, 1'b1);
    cyc(0, 1, 0, 8'h00, 0, 1);
    chk("t1_rd_base", bus.cfg_rdata, 8'h00);
    chk("t1_en", en_flat, 16'h0000);
    cyc(0, 0, 0, 8'h00, 0, 1);
    chk("t1_rvalid_drop", bus.cfg_rvalid, 1'b0);
    // BASE w1 write then commit
    cyc(1, 0, 4, 8'h78, 0, 1);
    cyc(1, 0, 5, 8'h56, 0, 1);
    cyc(1, 0, 6, 8'h34, 0, 1);
    cyc(1, 0, 7, 8'h12, 0, 1);
    chk("t2_base_pre", base_flat[63:32], 32'h0);
    cyc(0, 1, 4, 8'h00, 0, 1);
    chk("t2_rd_shadow", bus.cfg_rdata, 8'h78);
    cyc(1, 0, CTRL_O, 8'h01, 0, 1);
    chk("t2_base_1edge", base_flat[63:32], 32'h0);
    cyc(0, 0, 0, 8'h00, 0, 1);
    chk("t2_base_2edge", base_flat[63:32], 32'h12345678);
    chk("t2_updated", cfg_updated, 1'b1);
    cyc(0, 0, 0, 8'h00, 0, 1);
    chk("t2_updated_once", cfg_updated, 1'b0);
    // commit held off by commit_hold
    cyc(1, 0, CTRL_O, 8'h01, 1, 1);
    cyc(1, 0, 130, 8'hFF, 1, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, CTRL_O, 8'h00, 1, 1);
      chk("t3_pending", bus.cfg_rdata[0], 1'b1);
      chk("t3_slot_held", slot_flat[8:6], 3'b000);
    end
    cyc(0, 0, 0, 8'h00, 0, 1);
    chk("t3_slot_applied", slot_flat[8:6], 3'b111);
    cyc(0, 0, 0, 8'h00, 0, 1);
    // lock and error clear
    cyc(1, 0, CTRL_O, 8'h02, 0, 1);
    cyc(1, 0, 0, 8'hAA, 0, 1);
    chk("t4_err_locked", cfg_err, 1'b1);
    cyc(0, 1, 0, 8'h00, 0, 1);
    chk("t4_shadow_kept", bus.cfg_rdata, 8'h00);
    cyc(1, 0, CTRL_O, 8'h04, 0, 1);
    chk("t4_err_clr", cfg_err, 1'b0);
    chk("t4_lock_sticky", cfg_locked, 1'b1);
    // out-of-range access
    cyc(1, 0, 200, 8'h55, 0, 1);
    chk("t5_err_oor", cfg_err, 1'b1);
    cyc(0, 1, 200, 8'h00, 0, 1);
    chk("t5_rd_oor", bus.cfg_rdata, 8'h00);
    chk("t5_err_kept", cfg_err, 1'b1);
    // same-cycle read/write, then reset during WAIT
    cyc(0, 0, 0, 8'h00, 0, 0);
    cyc(1, 1, EN_O, 8'h01, 0, 1);
    chk("t6_rd_old", bus.cfg_rdata, 8'h00);
    cyc(0, 1, EN_O, 8'h00, 0, 1);
    chk("t6_rd_new", bus.cfg_rdata, 8'h01);
    cyc(1, 0, CTRL_O, 8'h01, 1, 1);
    cyc(0, 0, 0, 8'h00, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 8'h00, 0, 1);
    chk("t6_en_default", en_flat, 16'h0000);
    chk("t6_op_default", op_flat, {16{8'hFF}});
    chk("t6_no_update", cfg_updated, 1'b0);
    // randomized traffic
    hold_v = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 10)      a = CTRL_O;
      else if (r < 15) a = $urandom_range(CTRL_O + 1, 1023);
      else             a = $urandom_range(0, CTRL_O - 1);
      we = ($urandom_range(0, 99) < 45);
      re = ($urandom_range(0, 99) < 45);
      d = 8'($urandom);
      if (a == CTRL_O) d[1] = ($urandom_range(0, 99) < 1);
      if ($urandom_range(0, 9) < 2) hold_v = !hold_v;
      rst = ($urandom_range(0, 499) != 0);
      cyc(we, re, a, d, hold_v, rst);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
